// File: rtl/microcomp_pkg.sv
// Shared constants for the microcomputer bus peripherals: DMA register map,
// CTRL bit positions and DMA sequencer state encoding.
package microcomp_pkg;

    localparam logic [15:0] DMA_BASE = 16'hE6E0;

    localparam logic [2:0] REG_SRC_L = 3'd0;
    localparam logic [2:0] REG_SRC_H = 3'd1;
    localparam logic [2:0] REG_DST_L = 3'd2;
    localparam logic [2:0] REG_DST_H = 3'd3;
    localparam logic [2:0] REG_LEN_L = 3'd4;
    localparam logic [2:0] REG_LEN_H = 3'd5;
    localparam logic [2:0] REG_CTRL  = 3'd6;
    localparam logic [2:0] REG_RSVD  = 3'd7;

    localparam int CTRL_START    = 0;
    localparam int CTRL_IE       = 1;
    localparam int CTRL_SRC_FIX  = 2;
    localparam int CTRL_DST_FIX  = 3;
    localparam int CTRL_CLR_DONE = 6;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_A = 3'd2;
    localparam logic [2:0] ST_RD_D = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

endpackage

// File: rtl/dma_regs.sv
// DMA slave register file: CPU-programmable address/length counters, control
// bits, done flag and the combinational readback mux.
module dma_regs
    import microcomp_pkg::*;
#(
    parameter int AW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [2:0]    AD,
    input  logic [7:0]    DI,
    input  logic          rw,
    output logic [7:0]    DO,
    input  logic          busy,
    input  logic          step,
    input  logic          fin,
    output logic [AW-1:0] src,
    output logic [AW-1:0] dst,
    output logic [LW-1:0] len,
    output logic          ie,
    output logic          done,
    output logic          start_go
);

    logic        src_fix;
    logic        dst_fix;
    logic        wr;
    logic        ctrl_wr;
    logic [15:0] src16;
    logic [15:0] dst16;
    logic [15:0] len16;
    logic        unused_di;

    assign src16     = 16'(src);
    assign dst16     = 16'(dst);
    assign len16     = 16'(len);
    assign unused_di = &{1'b0, DI[7], DI[5:4]};

    // The sequencer owns the counters while busy, so CPU writes are dropped then.
    assign wr       = cs & ~rw & ~busy;
    assign ctrl_wr  = wr && (AD == REG_CTRL);
    assign start_go = ctrl_wr && DI[CTRL_START] && (len != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            ie      <= 1'b0;
            src_fix <= 1'b0;
            dst_fix <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (step) begin
                if (!src_fix) src <= src + AW'(1);
                if (!dst_fix) dst <= dst + AW'(1);
                len <= len - LW'(1);
            end
            if (wr) begin
                case (AD)
                    REG_SRC_L: src <= AW'({src16[15:8], DI});
                    REG_SRC_H: src <= AW'({DI, src16[7:0]});
                    REG_DST_L: dst <= AW'({dst16[15:8], DI});
                    REG_DST_H: dst <= AW'({DI, dst16[7:0]});
                    REG_LEN_L: len <= LW'({len16[15:8], DI});
                    REG_LEN_H: len <= LW'({DI, len16[7:0]});
                    REG_CTRL: begin
                        ie      <= DI[CTRL_IE];
                        src_fix <= DI[CTRL_SRC_FIX];
                        dst_fix <= DI[CTRL_DST_FIX];
                    end
                    default: ;
                endcase
            end
            // A zero-length start completes immediately; start beats the clear bit.
            if (fin) begin
                done <= 1'b1;
            end else if (ctrl_wr) begin
                if (DI[CTRL_START]) done <= (len == '0);
                else if (DI[CTRL_CLR_DONE]) done <= 1'b0;
            end
        end
    end

    always_comb begin
        DO = 8'h00;
        case (AD)
            REG_SRC_L: DO = src16[7:0];
            REG_SRC_H: DO = src16[15:8];
            REG_DST_L: DO = dst16[7:0];
            REG_DST_H: DO = dst16[15:8];
            REG_LEN_L: DO = len16[7:0];
            REG_LEN_H: DO = len16[15:8];
            REG_CTRL:  DO = {busy, done, 2'b00, dst_fix, src_fix, ie, 1'b0};
            default:   DO = 8'h00;
        endcase
    end

endmodule

// File: rtl/dma_ctrl.sv
// Bus-mastering byte-copy DMA: requests the bus with hold, then runs
// read-address / read-data / write cycles per byte until LEN reaches zero.
module dma_ctrl
    import microcomp_pkg::*;
#(
    parameter int AW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [2:0]    AD,
    input  logic [7:0]    DI,
    output logic [7:0]    DO,
    input  logic          rw,
    output logic          hold,
    input  logic          hold_ack,
    output logic          m_own,
    output logic [AW-1:0] m_addr,
    output logic [7:0]    m_dout,
    output logic          m_read,
    input  logic [7:0]    m_din,
    output logic          irq,
    output logic [2:0]    dbg_state
);

    // Bus handshake: the master may drive the bus only in a cycle where
    // hold = 1 and hold_ack = 1; dropping hold_ack freezes the sequencer.
    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [7:0]    buf_q;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic          ie;
    logic          done;
    logic          start_go;
    logic          busy;
    logic          bus_phase;
    logic          step;
    logic          fin;

    assign busy      = (state == ST_REQ) || (state == ST_RD_A) ||
                       (state == ST_RD_D) || (state == ST_WR);
    assign bus_phase = (state == ST_RD_A) || (state == ST_RD_D) || (state == ST_WR);
    assign step      = (state == ST_WR) && hold_ack;
    assign fin       = (state == ST_FIN);

    dma_regs #(.AW(AW), .LW(LW)) u_regs (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .AD       (AD),
        .DI       (DI),
        .rw       (rw),
        .DO       (DO),
        .busy     (busy),
        .step     (step),
        .fin      (fin),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .ie       (ie),
        .done     (done),
        .start_go (start_go)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start_go) state_nx = ST_REQ;
            ST_REQ:  if (hold_ack) state_nx = ST_RD_A;
            ST_RD_A: if (hold_ack) state_nx = ST_RD_D;
            // Losing the bus mid-read restarts the read so the SRAM latency is re-covered.
            ST_RD_D: state_nx = hold_ack ? ST_WR : ST_RD_A;
            ST_WR:   if (hold_ack) state_nx = (len == LW'(1)) ? ST_FIN : ST_RD_A;
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            buf_q <= 8'h00;
        end else begin
            state <= state_nx;
            if ((state == ST_RD_D) && hold_ack) buf_q <= m_din;
        end
    end

    assign hold      = busy;
    assign m_own     = bus_phase & hold_ack;
    assign m_read    = (state != ST_WR);
    assign m_dout    = (state == ST_WR) ? buf_q : 8'h00;
    assign m_addr    = ((state == ST_RD_A) || (state == ST_RD_D)) ? src :
                       (state == ST_WR) ? dst : '0;
    assign irq       = done & ie;
    assign dbg_state = state;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: register vector table plus copy, fixed-dest,
// wrap, zero-length, stall and reset sequences against a bench SRAM model.
module tb_dma_ctrl;
    import microcomp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic [2:0]  AD;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        rw;
    logic        hold;
    logic        hold_ack;
    logic        m_own;
    logic [15:0] m_addr;
    logic [7:0]  m_dout;
    logic        m_read;
    logic [7:0]  m_din;
    logic        irq;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    dma_ctrl #(.AW(16), .LW(16)) dut (
        .clk(clk), .rst(rst), .cs(cs), .AD(AD), .DI(DI), .DO(DO), .rw(rw),
        .hold(hold), .hold_ack(hold_ack), .m_own(m_own), .m_addr(m_addr),
        .m_dout(m_dout), .m_read(m_read), .m_din(m_din), .irq(irq),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Bus environment: CPU grants hold two clocks after the request.
    logic [1:0]  hd;
    logic        stall;
    logic        ack_block;
    logic [7:0]  mem [0:65535];
    logic [7:0]  rdata;
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    assign hold_ack = hold & hd[1] & ~stall & ~ack_block;
    assign m_din    = rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) hd <= 2'b00;
        else      hd <= {hd[0], hold};
    end

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (m_own && !m_read) mem[m_addr] <= m_dout;
        rdata <= mem[m_addr];
    end

    // Bus activity log.
    logic        log_clr;
    int          log_n;
    int          own_cnt;
    int          rd_n;
    logic        hold_seen;
    logic [15:0] log_addr [0:15];
    logic [7:0]  log_data [0:15];
    logic [15:0] rd_addr  [0:31];

    always @(posedge clk) begin
        if (log_clr) begin
            log_n     <= 0;
            own_cnt   <= 0;
            rd_n      <= 0;
            hold_seen <= 1'b0;
        end else begin
            if (m_own) own_cnt <= own_cnt + 1;
            if (hold) hold_seen <= 1'b1;
            if (m_own && !m_read && log_n < 16) begin
                log_addr[log_n] <= m_addr;
                log_data[log_n] <= m_dout;
                log_n <= log_n + 1;
            end
            if (m_own && m_read && rd_n < 32) begin
                rd_addr[rd_n] <= m_addr;
                rd_n <= rd_n + 1;
            end
        end
    end

    typedef struct {
        logic       wr;
        logic [2:0] ad;
        logic [7:0] data;
        logic [7:0] exp;
        logic       exp_irq;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] ad, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = ad; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1; DI = 8'h00;
    endtask

    task automatic rd_now(input string name, input logic [2:0] ad, input logic [7:0] exp);
        AD = ad;
        #1;
        check(name, {24'h0, DO}, {24'h0, exp});
    endtask

    task automatic rd_chk(input string name, input logic [2:0] ad, input logic [7:0] exp);
        @(negedge clk);
        rd_now(name, ad, exp);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic set_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        wr_reg(REG_SRC_L, s[7:0]);
        wr_reg(REG_SRC_H, s[15:8]);
        wr_reg(REG_DST_L, d[7:0]);
        wr_reg(REG_DST_H, d[15:8]);
        wr_reg(REG_LEN_L, n[7:0]);
        wr_reg(REG_LEN_H, n[15:8]);
    endtask

    task automatic clr_log();
        @(negedge clk);
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        AD = REG_CTRL;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (DO[6]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: done flag got 0 expected 1 within 300 cycles", name);
        end
    endtask

    initial begin
        cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
        stall = 1'b0; ack_block = 1'b0; pl_en = 1'b0; pl_addr = 16'h0; pl_data = 8'h0;
        log_clr = 1'b1;
        rst = 1'b0;

        vt[0]  = '{1'b1, REG_SRC_L, 8'h34, 8'h00, 1'b0};
        vt[1]  = '{1'b1, REG_SRC_H, 8'h12, 8'h00, 1'b0};
        vt[2]  = '{1'b1, REG_DST_L, 8'h78, 8'h00, 1'b0};
        vt[3]  = '{1'b1, REG_DST_H, 8'h56, 8'h00, 1'b0};
        vt[4]  = '{1'b1, REG_LEN_L, 8'h9A, 8'h00, 1'b0};
        vt[5]  = '{1'b1, REG_LEN_H, 8'hBC, 8'h00, 1'b0};
        vt[6]  = '{1'b1, REG_CTRL,  8'h0E, 8'h00, 1'b0};
        vt[7]  = '{1'b0, REG_SRC_L, 8'h00, 8'h34, 1'b0};
        vt[8]  = '{1'b0, REG_SRC_H, 8'h00, 8'h12, 1'b0};
        vt[9]  = '{1'b0, REG_DST_L, 8'h00, 8'h78, 1'b0};
        vt[10] = '{1'b0, REG_DST_H, 8'h00, 8'h56, 1'b0};
        vt[11] = '{1'b0, REG_LEN_L, 8'h00, 8'h9A, 1'b0};
        vt[12] = '{1'b0, REG_LEN_H, 8'h00, 8'hBC, 1'b0};
        vt[13] = '{1'b0, REG_CTRL,  8'h00, 8'h0E, 1'b0};
        vt[14] = '{1'b0, REG_RSVD,  8'h00, 8'h00, 1'b0};
        vt[15] = '{1'b1, REG_RSVD,  8'hFF, 8'h00, 1'b0};
        vt[16] = '{1'b0, REG_RSVD,  8'h00, 8'h00, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_hold", {31'h0, hold}, 32'h0);
        check("rst_m_own", {31'h0, m_own}, 32'h0);
        check("rst_m_read", {31'h0, m_read}, 32'h1);
        check("rst_m_addr", {16'h0, m_addr}, 32'h0);
        check("rst_m_dout", {24'h0, m_dout}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd_now("rst_ctrl", REG_CTRL, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;

        // Register vector table
        for (int i = 0; i < 17; i++) begin
            if (vt[i].wr) begin
                wr_reg(vt[i].ad, vt[i].data);
            end else begin
                rd_chk($sformatf("vec%0d_do", i), vt[i].ad, vt[i].exp);
                check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vt[i].exp_irq});
            end
        end
        wr_reg(REG_CTRL, 8'h00);

        // Zero-length start
        clr_log();
        set_regs(16'h1234, 16'h5678, 16'h0000);
        wr_reg(REG_CTRL, 8'h03);
        rd_now("zl_ctrl", REG_CTRL, 8'h42);
        check("zl_irq", {31'h0, irq}, 32'h1);
        repeat (4) @(negedge clk);
        #1;
        check("zl_no_hold", {31'h0, hold_seen}, 32'h0);
        check("zl_irq_held", {31'h0, irq}, 32'h1);
        wr_reg(REG_CTRL, 8'h42);
        rd_now("zl_clr_ctrl", REG_CTRL, 8'h02);
        check("zl_clr_irq", {31'h0, irq}, 32'h0);
        wr_reg(REG_CTRL, 8'h00);

        // Basic copy
        preload(16'h0010, 8'h11);
        preload(16'h0011, 8'h22);
        preload(16'h0012, 8'h33);
        preload(16'h0013, 8'h44);
        clr_log();
        set_regs(16'h0010, 16'h0100, 16'd4);
        wr_reg(REG_CTRL, 8'h01);
        wait_done("copy_wait");
        check("copy_own_cycles", own_cnt, 32'd12);
        check("copy_writes", log_n, 32'd4);
        check("copy_m0", {24'h0, mem[16'h0100]}, 32'h11);
        check("copy_m1", {24'h0, mem[16'h0101]}, 32'h22);
        check("copy_m2", {24'h0, mem[16'h0102]}, 32'h33);
        check("copy_m3", {24'h0, mem[16'h0103]}, 32'h44);
        rd_chk("copy_src_l", REG_SRC_L, 8'h14);
        rd_chk("copy_src_h", REG_SRC_H, 8'h00);
        rd_chk("copy_dst_l", REG_DST_L, 8'h04);
        rd_chk("copy_dst_h", REG_DST_H, 8'h01);
        rd_chk("copy_len_l", REG_LEN_L, 8'h00);
        rd_chk("copy_len_h", REG_LEN_H, 8'h00);
        rd_chk("copy_ctrl", REG_CTRL, 8'h40);
        check("copy_irq", {31'h0, irq}, 32'h0);

        // Fixed destination (UART data port)
        preload(16'h0020, 8'hA1);
        preload(16'h0021, 8'hB2);
        preload(16'h0022, 8'hC3);
        clr_log();
        set_regs(16'h0020, 16'hE6B0, 16'd3);
        wr_reg(REG_CTRL, 8'h09);
        wait_done("fix_wait");
        check("fix_writes", log_n, 32'd3);
        check("fix_a0", {16'h0, log_addr[0]}, 32'hE6B0);
        check("fix_a1", {16'h0, log_addr[1]}, 32'hE6B0);
        check("fix_a2", {16'h0, log_addr[2]}, 32'hE6B0);
        check("fix_d0", {24'h0, log_data[0]}, 32'hA1);
        check("fix_d1", {24'h0, log_data[1]}, 32'hB2);
        check("fix_d2", {24'h0, log_data[2]}, 32'hC3);
        rd_chk("fix_dst_l", REG_DST_L, 8'hB0);
        rd_chk("fix_dst_h", REG_DST_H, 8'hE6);
        rd_chk("fix_src_l", REG_SRC_L, 8'h23);
        rd_chk("fix_ctrl", REG_CTRL, 8'h48);

        // Source address wrap
        preload(16'hFFFF, 8'h5A);
        preload(16'h0000, 8'hA5);
        clr_log();
        set_regs(16'hFFFF, 16'h0200, 16'd2);
        wr_reg(REG_CTRL, 8'h01);
        wait_done("wrap_wait");
        check("wrap_rd0", {16'h0, rd_addr[0]}, 32'hFFFF);
        check("wrap_rd2", {16'h0, rd_addr[2]}, 32'h0000);
        check("wrap_m0", {24'h0, mem[16'h0200]}, 32'h5A);
        check("wrap_m1", {24'h0, mem[16'h0201]}, 32'hA5);
        rd_chk("wrap_src_l", REG_SRC_L, 8'h01);
        rd_chk("wrap_src_h", REG_SRC_H, 8'h00);
        rd_chk("wrap_len_l", REG_LEN_L, 8'h00);

        // hold_ack dropped for 3 clk during RD_D of byte 2
        preload(16'h0030, 8'h01);
        preload(16'h0031, 8'h02);
        preload(16'h0032, 8'h03);
        preload(16'h0033, 8'h04);
        clr_log();
        set_regs(16'h0030, 16'h0300, 16'd4);
        wr_reg(REG_CTRL, 8'h01);
        begin
            int seen;
            logic found;
            seen = 0;
            found = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (dbg_state == ST_RD_D) begin
                    seen++;
                    if (seen == 2) begin
                        found = 1'b1;
                        break;
                    end
                end
            end
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL stall_find: second RD_D got none expected within 200 cycles");
            end
        end
        stall = 1'b1;
        #1;
        check("stall_own0", {31'h0, m_own}, 32'h0);
        check("stall_hold0", {31'h0, hold}, 32'h1);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("stall_own%0d", i), {31'h0, m_own}, 32'h0);
            check($sformatf("stall_state%0d", i), {29'h0, dbg_state}, {29'h0, ST_RD_A});
            check($sformatf("stall_hold%0d", i), {31'h0, hold}, 32'h1);
        end
        @(negedge clk);
        stall = 1'b0;
        wait_done("stall_wait");
        check("stall_writes", log_n, 32'd4);
        check("stall_own_cycles", own_cnt, 32'd13);
        check("stall_m0", {24'h0, mem[16'h0300]}, 32'h01);
        check("stall_m1", {24'h0, mem[16'h0301]}, 32'h02);
        check("stall_m2", {24'h0, mem[16'h0302]}, 32'h03);
        check("stall_m3", {24'h0, mem[16'h0303]}, 32'h04);
        rd_chk("stall_src_l", REG_SRC_L, 8'h34);
        rd_chk("stall_len_l", REG_LEN_L, 8'h00);

        // Reset while waiting for the bus grant
        ack_block = 1'b1;
        set_regs(16'h0010, 16'h0400, 16'd4);
        wr_reg(REG_CTRL, 8'h03);
        #1;
        check("mid_req_hold", {31'h0, hold}, 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_hold", {31'h0, hold}, 32'h0);
        check("mid_rst_own", {31'h0, m_own}, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        check("mid_rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        rd_now("mid_rst_ctrl", REG_CTRL, 8'h00);
        rd_now("mid_rst_src", REG_SRC_L, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        ack_block = 1'b0;
        clr_log();
        repeat (3) @(negedge clk);
        check("mid_rst_no_resume", {31'h0, hold_seen}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- Memory-mapped DMA controller that sequences byte copies over the shared CPU bus (SRAM, UART, GPIO).
- Programmed by the CPU through 8 slave registers decoded at $E6E0 (DS7).
- To run a transfer it requests the bus with `hold`, waits for `hold_ack`, then drives address, data and read/write itself. Top-level muxes switch ADDR/DO/RW to the master outputs while `m_own` = 1.
- Raises a done flag and an optional level IRQ on completion.

Parameters:
- AW, 16, bus address width.
- LW, 16, transfer length counter width.

Ports:
- clk  in  1  system clock (single clock domain).
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  slave select (register window).
- AD  in  3  slave register index.
- DI  in  8  slave write data (CPU DO).
- DO  out  8  slave read data.
- rw  in  1  1 = read, 0 = write (CPU RW).
- hold  out  1  bus request to CPU.
- hold_ack  in  1  CPU has released the bus.
- m_own  out  1  master owns bus (top-level mux select).
- m_addr  out  AW  master address.
- m_dout  out  8  master write data.
- m_read  out  1  master 1 = read, 0 = write.
- m_din  in  8  master read data (top-level DI).
- irq  out  1  level interrupt = done & ie.

Behaviour:
Register map (AD):
- 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H: all R/W; reads return live counters.
- 6 CTRL:
  - Write: bit0 start, bit1 ie, bit2 src_fix, bit3 dst_fix, bit6 = 1 clears done.
  - Read: {busy, done, 2'b0, dst_fix, src_fix, ie, 0}.
- 7: reads 8'h00; writes ignored.

Slave timing:
- Writes take effect on the clk edge where cs = 1 and rw = 0.
- DO is combinational from AD.
- Slave writes while busy are ignored. The CPU is stalled then, so this is a safety rule only.

Reset (rst = 0, async):
- All registers 0, FSM IDLE.
- hold = 0, m_own = 0, m_read = 1, m_addr = 0, m_dout = 0, irq = 0, done = 0.

FSM states: IDLE, REQ, RD_A, RD_D, WR, FIN.
- IDLE: a start write with LEN != 0 → REQ, busy = 1, done cleared. A start write with LEN = 0 → done = 1 next cycle, stays IDLE, no hold.
- REQ: hold = 1; when hold_ack = 1 → RD_A.
- RD_A: m_own = 1, m_addr = SRC, m_read = 1 → RD_D. Covers the synchronous SRAM 1-cycle read latency.
- RD_D: m_own = 1, m_addr = SRC, m_read = 1; latch m_din into the data buffer → WR.
- WR: m_own = 1, m_addr = DST, m_dout = buffer, m_read = 0.
  - On exit: SRC += 1 unless src_fix; DST += 1 unless dst_fix; LEN -= 1.
  - If the old LEN was 1 → FIN, else → RD_A.
- FIN: hold = 0, m_own = 0, busy = 0, done = 1 → IDLE.

Timing and arithmetic:
- Throughput: 3 clk per byte.
- Latency from start write to first bus cycle: 1 clk plus hold_ack wait.
- Address increments wrap modulo 2^AW ($FFFF + 1 = $0000). LEN is unsigned.

hold_ack drop mid-transfer:
- m_own falls combinationally with hold_ack.
- In RD_A or WR: hold state, no counter update.
- In RD_D: return to RD_A; the buffer is not latched.
- hold stays 1 throughout.

Other boundaries:
- Reset mid-transfer: immediate idle; no partial write is completed beyond the current cycle.
- done and start in the same write: start wins, done = 0.
- irq = done & ie, combinational from registers.

Decomposition:
- Shared package (microcomp_pkg): register index constants (REG_SRC_L..REG_CTRL), CTRL bit positions, FSM state encoding, DMA base $E6E0.
- One natural sub-module, dma_regs: slave register file and readback mux. The FSM and master datapath live in dma_ctrl.

Test Plan:
- Reset: rst low mid-REQ → hold = 0, m_own = 0, CTRL reads 8'h00, irq = 0.
- Copy: SRC = $0010, DST = $0100, LEN = 4, SRAM[$10..$13] = 11,22,33,44; start, hold_ack tied to hold after 2 clk.
  - Expect SRAM[$100..$103] = 11,22,33,44 and 12 master cycles.
  - Expect final SRC = $0014, DST = $0104, LEN = 0, CTRL = 8'h40.
- Fixed destination: DST = $E6B0 (UART), dst_fix = 1, LEN = 3 → three writes all at $E6B0 with the source bytes in order; DST unchanged.
- Wrap: SRC = $FFFF, LEN = 2 → reads at $FFFF then $0000; final SRC = $0001.
- Edge cases:
  - LEN = 0 start → hold never asserted, done = 1 after 1 clk.
  - ie = 1 → irq = 1 until a write of CTRL bit6 = 1.
- Stall: hold_ack dropped for 3 clk during RD_D of byte 2 → m_own = 0 while low, byte re-read from RD_A, destination data correct, LEN decremented exactly once per byte.
